// File: rtl/usb_audio_pkg.sv
// usb_audio_pkg
// Shared constants, types and helpers for the USB audio gain path.
//   GAIN_WIDTH   : width of a per-channel gain (0..256, 256 = unity)
//   GAIN_UNITY   : unity gain value
//   ROUND_CONST  : half-LSB added before the >>> 8 that removes the gain scale
//   vol_to_gain  : maps an 8-bit USB volume onto the 9-bit gain range
//   step_dir     : which way a current gain must move to reach its target
//   apply_step   : moves a gain one unit in the given direction
package usb_audio_pkg;

    localparam int               GAIN_WIDTH         = 9;
    localparam logic [8:0]       GAIN_UNITY         = 9'd256;
    localparam int               ROUND_CONST        = 128;
    localparam int               DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        STEP_HOLD = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2
    } step_e;

    // 0xFF lands exactly on unity by adding the volume MSB back in.
    function automatic logic [GAIN_WIDTH-1:0] vol_to_gain(input logic [7:0] vol);
        return {1'b0, vol} + {8'd0, vol[7]};
    endfunction

    function automatic step_e step_dir(input logic [GAIN_WIDTH-1:0] gain,
                                       input logic [GAIN_WIDTH-1:0] target);
        step_e dir;
        if ((gain < target) && (gain < GAIN_UNITY)) begin
            dir = STEP_UP;
        end else if (gain > target) begin
            dir = STEP_DOWN;
        end else begin
            dir = STEP_HOLD;
        end
        return dir;
    endfunction

    function automatic logic [GAIN_WIDTH-1:0] apply_step(input logic [GAIN_WIDTH-1:0] gain,
                                                         input step_e dir);
        logic [GAIN_WIDTH-1:0] next;
        case (dir)
            STEP_UP:   next = gain + 9'd1;
            STEP_DOWN: next = gain - 9'd1;
            STEP_HOLD: next = gain;
            default:   next = gain;
        endcase
        return next;
    endfunction

endpackage

// File: rtl/usb_gain_mult.sv
// usb_gain_mult
// One channel of the two-stage gain pipeline: stage 1 registers the
// sample x gain product, stage 2 registers the rounded, rescaled result.
//   clk, reset    : clock, synchronous active-high reset
//   valid, sample : input strobe and signed sample
//   gain          : 9-bit unsigned gain applied to this sample (256 = unity)
//   result        : signed result, held between strobes
//   result_valid  : valid delayed by two cycles
module usb_gain_mult
    import usb_audio_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid,
    input  logic signed [DATA_WIDTH-1:0] sample,
    input  logic [GAIN_WIDTH-1:0]        gain,
    output logic signed [DATA_WIDTH-1:0] result,
    output logic                         result_valid
);

    localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
    localparam logic signed [PW-1:0] ROUND_W = PW'(ROUND_CONST);

    logic signed [PW-1:0]         product_s;
    logic signed [PW-1:0]         product_r;
    logic signed [PW-1:0]         rounded_s;
    logic signed [DATA_WIDTH-1:0] result_next_s;
    logic signed [DATA_WIDTH-1:0] result_r;
    logic                         valid_r;
    logic                         result_valid_r;

    // Product and round-half-up rescale; gain <= 256 keeps the result in range.
    always_comb begin
        product_s     = PW'(sample) * PW'($signed({1'b0, gain}));
        rounded_s     = product_r + ROUND_W;
        result_next_s = DATA_WIDTH'(rounded_s >>> 4'd8);
    end

    // Stage 1 and stage 2 registers; data holds when no strobe passes.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r        <= 1'b0;
            product_r      <= '0;
            result_valid_r <= 1'b0;
            result_r       <= '0;
        end else begin
            valid_r        <= valid;
            result_valid_r <= valid_r;
            if (valid) begin
                product_r <= product_s;
            end else begin
                product_r <= product_r;
            end
            if (valid_r) begin
                result_r <= result_next_s;
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign result       = result_r;
    assign result_valid = result_valid_r;

endmodule

// File: rtl/usb_volume_ramp.sv
// usb_volume_ramp
// Applies slewed per-channel gain to the stereo PCM stream. Gains move one
// unit toward their targets every RAMP_DIV accepted samples so volume, mute
// and stream start/stop never produce a step discontinuity.
//   Clk, Reset                 : clock, synchronous active-high reset
//   Active, Mute               : stream alternate setting and mute request
//   Volume_Left/Volume_Right   : 8-bit USB volumes
//   In_Valid/In_Left/In_Right  : input sample strobe and stereo sample
//   Out_Valid/Out_Left/Out_Right : processed sample, two cycles later
//   Ramping                    : a current gain differs from its target
//   Silent                     : both current gains are zero
module usb_volume_ramp
    import usb_audio_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int RAMP_DIV       = 48,
    parameter int RAMP_CNT_WIDTH = 6
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Active,
    input  logic                         Mute,
    input  logic [7:0]                   Volume_Left,
    input  logic [7:0]                   Volume_Right,
    input  logic                         In_Valid,
    input  logic signed [DATA_WIDTH-1:0] In_Left,
    input  logic signed [DATA_WIDTH-1:0] In_Right,
    output logic                         Out_Valid,
    output logic signed [DATA_WIDTH-1:0] Out_Left,
    output logic signed [DATA_WIDTH-1:0] Out_Right,
    output logic                         Ramping,
    output logic                         Silent
);

    localparam logic [RAMP_CNT_WIDTH-1:0] RAMP_LAST = RAMP_CNT_WIDTH'(RAMP_DIV - 1);

    logic [GAIN_WIDTH-1:0]     target_left_s;
    logic [GAIN_WIDTH-1:0]     target_right_s;
    logic [GAIN_WIDTH-1:0]     gain_left_r;
    logic [GAIN_WIDTH-1:0]     gain_right_r;
    logic [RAMP_CNT_WIDTH-1:0] ramp_cnt_r;
    logic                      step_s;
    logic                      ramping_r;
    logic                      silent_r;
    logic                      valid_left_s;
    logic                      valid_right_s;

    // Targets follow the control registers every cycle; mute dominates volume.
    always_comb begin
        target_left_s  = '0;
        target_right_s = '0;
        if (Mute || !Active) begin
            target_left_s  = '0;
            target_right_s = '0;
        end else begin
            target_left_s  = vol_to_gain(Volume_Left);
            target_right_s = vol_to_gain(Volume_Right);
        end
        step_s = In_Valid && (ramp_cnt_r == RAMP_LAST);
    end

    // Ramp divider and gain slew; status flags look at the pre-step gains.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ramp_cnt_r   <= '0;
            gain_left_r  <= '0;
            gain_right_r <= '0;
            ramping_r    <= 1'b0;
            silent_r     <= 1'b1;
        end else begin
            if (step_s) begin
                ramp_cnt_r   <= '0;
                gain_left_r  <= apply_step(gain_left_r, step_dir(gain_left_r, target_left_s));
                gain_right_r <= apply_step(gain_right_r, step_dir(gain_right_r, target_right_s));
            end else if (In_Valid) begin
                ramp_cnt_r   <= ramp_cnt_r + RAMP_CNT_WIDTH'(1);
                gain_left_r  <= gain_left_r;
                gain_right_r <= gain_right_r;
            end else begin
                ramp_cnt_r   <= ramp_cnt_r;
                gain_left_r  <= gain_left_r;
                gain_right_r <= gain_right_r;
            end
            ramping_r <= (gain_left_r != target_left_s) || (gain_right_r != target_right_s);
            silent_r  <= (gain_left_r == '0) && (gain_right_r == '0);
        end
    end

    // The sample that triggers a step still sees the pre-step gain.
    usb_gain_mult #(.DATA_WIDTH(DATA_WIDTH)) u_mult_left (
        .clk          (Clk),
        .reset        (Reset),
        .valid        (In_Valid),
        .sample       (In_Left),
        .gain         (gain_left_r),
        .result       (Out_Left),
        .result_valid (valid_left_s)
    );

    usb_gain_mult #(.DATA_WIDTH(DATA_WIDTH)) u_mult_right (
        .clk          (Clk),
        .reset        (Reset),
        .valid        (In_Valid),
        .sample       (In_Right),
        .gain         (gain_right_r),
        .result       (Out_Right),
        .result_valid (valid_right_s)
    );

    assign Out_Valid = valid_left_s & valid_right_s;
    assign Ramping   = ramping_r;
    assign Silent    = silent_r;

endmodule

// File: tb/tb_usb_volume_ramp.sv
// tb_usb_volume_ramp
// Randomized bench for usb_volume_ramp (RAMP_DIV=2 to keep ramps short).
// A behavioural model tracks gains as integers and the expected outputs as a
// queue of pending results with their due cycle.
module tb_usb_volume_ramp;

    localparam int DW  = 16;
    localparam int DIV = 2;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              Active = 1'b0;
    logic              Mute = 1'b0;
    logic [7:0]        Volume_Left = 8'd0;
    logic [7:0]        Volume_Right = 8'd0;
    logic              In_Valid = 1'b0;
    logic signed [DW-1:0] In_Left = '0;
    logic signed [DW-1:0] In_Right = '0;
    logic              Out_Valid;
    logic signed [DW-1:0] Out_Left;
    logic signed [DW-1:0] Out_Right;
    logic              Ramping;
    logic              Silent;

    always #5 Clk = ~Clk;

    usb_volume_ramp #(
        .DATA_WIDTH     (DW),
        .RAMP_DIV       (DIV),
        .RAMP_CNT_WIDTH (1)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Active       (Active),
        .Mute         (Mute),
        .Volume_Left  (Volume_Left),
        .Volume_Right (Volume_Right),
        .In_Valid     (In_Valid),
        .In_Left      (In_Left),
        .In_Right     (In_Right),
        .Out_Valid    (Out_Valid),
        .Out_Left     (Out_Left),
        .Out_Right    (Out_Right),
        .Ramping      (Ramping),
        .Silent       (Silent)
    );

    typedef struct {
        int due;
        int l;
        int r;
    } pend_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    m_gain [2];
    int    m_cnt;
    pend_t q [$];
    int    e_l, e_r;
    bit    e_valid, e_ramp, e_silent;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int target_of(input bit act, input bit mute, input logic [7:0] v);
        int t;
        if (mute || !act) t = 0;
        else if (v >= 8'd128) t = int'(v) + 1;
        else t = int'(v);
        return t;
    endfunction

    // floor((s*g + 128) / 256)
    function automatic int scaled(input int s, input int g);
        int p;
        p = s * g + 128;
        return p >>> 8;
    endfunction

    function automatic int rand_sample();
        int s;
        case ($urandom_range(0, 7))
            0: s = 32767;
            1: s = -32768;
            2: s = 3;
            3: s = -3;
            default: s = int'($urandom_range(0, 65535)) - 32768;
        endcase
        return s;
    endfunction

    function automatic int toward(input int g, input int t);
        int n;
        if (g < t) n = g + 1;
        else if (g > t) n = g - 1;
        else n = g;
        return n;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, check outputs.
    task automatic cycle(input bit rst, input bit act, input bit mute,
                         input logic [7:0] vl, input logic [7:0] vr,
                         input bit iv, input int sl, input int sr);
        int tl, tr;
        Reset = rst; Active = act; Mute = mute;
        Volume_Left = vl; Volume_Right = vr;
        In_Valid = iv; In_Left = DW'(sl); In_Right = DW'(sr);
        @(posedge Clk);
        cyc++;
        if (rst) begin
            m_gain[0] = 0; m_gain[1] = 0; m_cnt = 0;
            q.delete();
            e_valid = 1'b0; e_l = 0; e_r = 0; e_ramp = 1'b0; e_silent = 1'b1;
        end else begin
            tl = target_of(act, mute, vl);
            tr = target_of(act, mute, vr);
            e_ramp   = (m_gain[0] != tl) || (m_gain[1] != tr);
            e_silent = (m_gain[0] == 0) && (m_gain[1] == 0);
            e_valid  = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e_valid = 1'b1; e_l = q[0].l; e_r = q[0].r;
                void'(q.pop_front());
            end
            if (iv) begin
                q.push_back('{cyc + 1, scaled(sl, m_gain[0]), scaled(sr, m_gain[1])});
                m_cnt++;
                if (m_cnt == DIV) begin
                    m_cnt = 0;
                    m_gain[0] = toward(m_gain[0], tl);
                    m_gain[1] = toward(m_gain[1], tr);
                end
            end
        end
        @(negedge Clk);
        check_eq("out_valid", int'(Out_Valid), int'(e_valid));
        check_eq("out_left",  int'(Out_Left),  e_l);
        check_eq("out_right", int'(Out_Right), e_r);
        check_eq("ramping",   int'(Ramping),   int'(e_ramp));
        check_eq("silent",    int'(Silent),    int'(e_silent));
    endtask

    initial begin
        bit         act, mute;
        logic [7:0] vl, vr;

        // Reset state
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 0, 0);

        // Ramp up to unity with a constant 0x4000 stream
        repeat (600) cycle(1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 16384, 16384);

        // Left down to 0x7F, random samples including full-scale and +/-3
        repeat (320) cycle(1'b0, 1'b1, 1'b0, 8'h7F, 8'hFF, 1'b1, rand_sample(), rand_sample());
        repeat (10) cycle(1'b0, 1'b1, 1'b0, 8'h7F, 8'hFF, 1'b1, 16384, 16384);

        // Ramp from 0 up, mute at about gain 100, release, regain target
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 0, 0);
        repeat (200) cycle(1'b0, 1'b1, 1'b0, 8'hFF, 8'hC0, 1'b1, rand_sample(), rand_sample());
        repeat (220) cycle(1'b0, 1'b1, 1'b1, 8'hFF, 8'hC0, 1'b1, rand_sample(), rand_sample());
        repeat (300) cycle(1'b0, 1'b1, 1'b0, 8'h80, 8'h40, 1'b1, rand_sample(), rand_sample());

        // Stream stop with gaps in In_Valid
        repeat (400) cycle(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, ($urandom_range(0, 2) == 0),
                           rand_sample(), rand_sample());

        // Random control changes with random strobes
        act = 1'b1; mute = 1'b0; vl = 8'hFF; vr = 8'h20;
        repeat (3000) begin
            if ($urandom_range(0, 63) == 0) act  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 63) == 0) mute = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 47) == 0) vl   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 47) == 0) vr   = 8'($urandom_range(0, 255));
            cycle(1'b0, act, mute, vl, vr, ($urandom_range(0, 3) != 0),
                  rand_sample(), rand_sample());
        end

        // Reset with two samples in flight, plus a sample on the reset cycle
        cycle(1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1000, -1000);
        cycle(1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 2000, -2000);
        cycle(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 3000, -3000);
        repeat (4) cycle(1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0, 0, 0);
        repeat (100) cycle(1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, rand_sample(), rand_sample());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
